dmem_byte_lane: RTL and testbench

Parametrised successor to the single-cycle core's data memory. It provides a word-organised RAM with byte/half/word loads and stores, RV32I funct3 sign/zero extension, and misalignment and illegal-op detection. Requests use a valid/ready handshake and every request gets a registered one-cycle response. A sequential init engine fills the array after reset. It sits between the core's load/store path and the memory array, and replaces direct byte-array indexing.

---
 rtl/dmem_pkg.sv | 31 +++
 rtl/dmem_byte_lane_if.sv | 32 +++
 rtl/dmem_load_align.sv | 47 ++++
 rtl/dmem_byte_lane.sv | 159 +++++++++++++++
 tb/tb_dmem_byte_lane.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the dmem_byte_lane data memory.
//   - RV32I load/store funct3 width codes
//   - FSM state enum for the init engine
//   - helpers: array index width, power-on fill pattern
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  // Number of word-index bits needed to address depth_words words.
  function automatic int idx_width(input int depth_words);
    return $clog2(depth_words);
  endfunction

  // Fill pattern: byte n of the memory holds n[7:0], so word k holds
  // {4k+3, 4k+2, 4k+1, 4k}, each truncated to 8 bits.
  function automatic logic [31:0] init_word(input logic [31:0] k);
    logic [7:0] b;
    b = {k[5:0], 2'b00};
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

endpackage

// File: rtl/dmem_byte_lane_if.sv
// dmem_byte_lane_if: request/response bundle between the core's load/store
// path (master) and the data memory (slave).
//   req_valid/req_ready  accept handshake
//   req_we, req_funct3   direction and RV32I width/sign code
//   req_addr, req_wdata  byte address and LSB-aligned store data
//   rsp_valid            one-cycle response pulse
//   rsp_rdata, rsp_error extended load data and error flag
//   init_busy            memory fill in progress
interface dmem_byte_lane_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_error;
  logic              init_busy;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error, init_busy
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_error, init_busy
  );
endinterface

// File: rtl/dmem_load_align.sv
// dmem_load_align: combinational load lane select and extension.
//   word    in  32  full memory word
//   lane    in  2   byte address bits [1:0]
//   funct3  in  3   RV32I load code
//   data    out 32  sign/zero-extended load result (0 on error)
//   error   out 1   illegal funct3 or misaligned half/word
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] data,
  output logic        error
);

  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  assign sel_b = word[8*lane +: 8];
  assign sel_h = lane[1] ? word[31:16] : word[15:0];

  // NOTE: every output of an always_comb gets a default first so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    data  = '0;
    error = 1'b0;
    case (funct3)
      F3_B:  data = {{24{sel_b[7]}}, sel_b};
      F3_BU: data = {24'd0, sel_b};
      F3_H: begin
        if (lane[0]) error = 1'b1;
        else         data  = {{16{sel_h[15]}}, sel_h};
      end
      F3_HU: begin
        if (lane[0]) error = 1'b1;
        else         data  = {16'd0, sel_h};
      end
      F3_W: begin
        if (lane != 2'b00) error = 1'b1;
        else               data  = word;
      end
      default: error = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_byte_lane.sv
// dmem_byte_lane: word-organised data RAM with byte/half/word access.
//   clk  in  rising-edge clock
//   rst  in  asynchronous active-high reset
//   bus  slave side of dmem_byte_lane_if (handshake, request, response,
//        init_busy)
// After reset an init engine fills one word per cycle; then requests are
// accepted every cycle and answered by a registered one-cycle response.
module dmem_byte_lane
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 32
) (
  input  logic            clk,
  input  logic            rst,
  dmem_byte_lane_if.slave bus
);

  localparam int IDX_W = idx_width(DEPTH_WORDS);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             run, busy;

  logic [31:0]      mem [DEPTH_WORDS];

  logic [IDX_W-1:0] word_idx;
  logic [1:0]       lane;
  logic             accept;

  logic [3:0]       store_be;
  logic [31:0]      store_data;
  logic             store_err;

  logic [31:0]      load_data;
  logic             load_err;
  logic             req_err;

  logic             rsp_valid_q;
  logic [31:0]      rsp_rdata_q;
  logic             rsp_error_q;

  // High address bits are deliberately ignored so addresses wrap.
  logic             unused_addr;
  assign unused_addr = ^bus.req_addr;

  assign word_idx = bus.req_addr[2 +: IDX_W];
  assign lane     = bus.req_addr[1:0];
  assign accept   = bus.req_valid && run;

  // ---------------------------------------------------------------- FSM
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    run     = 1'b0;
    busy    = 1'b0;
    case (state_q)
      INIT: begin
        busy  = 1'b1;
        cnt_d = cnt_q + IDX_W'(1);
        if (cnt_q == IDX_W'(DEPTH_WORDS - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN:     run = 1'b1;
      default: state_d = INIT;
    endcase
  end

  assign bus.req_ready = run;
  assign bus.init_busy = busy;

  // -------------------------------------------------------- store lanes
  // Store data is replicated across lanes; the byte enables pick which
  // lanes actually land.
  always_comb begin
    store_be   = '0;
    store_data = '0;
    store_err  = 1'b0;
    case (bus.req_funct3)
      F3_B: begin
        store_be   = 4'b0001 << lane;
        store_data = {4{bus.req_wdata[7:0]}};
      end
      F3_H: begin
        if (lane[0]) store_err = 1'b1;
        else begin
          store_be   = 4'b0011 << lane;
          store_data = {2{bus.req_wdata[15:0]}};
        end
      end
      F3_W: begin
        if (lane != 2'b00) store_err = 1'b1;
        else begin
          store_be   = 4'b1111;
          store_data = bus.req_wdata;
        end
      end
      default: store_err = 1'b1;
    endcase
  end

  // --------------------------------------------------------------- array
  // NOTE: the array has no reset; its contents are defined by the init
  // engine, which every reset restarts.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      mem[cnt_q] <= init_word(32'(cnt_q));
    end else if (accept && bus.req_we && !store_err) begin
      for (int b = 0; b < 4; b++) begin
        if (store_be[b]) mem[word_idx][8*b +: 8] <= store_data[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------- load path
  // Read is asynchronous into the aligner and captured on the accepting
  // edge, so a load right after a store to the same word sees the new data.
  dmem_load_align u_align (
    .word   (mem[word_idx]),
    .lane   (lane),
    .funct3 (bus.req_funct3),
    .data   (load_data),
    .error  (load_err)
  );

  assign req_err = bus.req_we ? store_err : load_err;

  // ------------------------------------------------------------ response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      rsp_valid_q <= accept;
      rsp_error_q <= accept && req_err;
      rsp_rdata_q <= (accept && !bus.req_we && !load_err) ? load_data : '0;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_error = rsp_error_q;

endmodule

// File: tb/tb_dmem_byte_lane.sv
// tb_dmem_byte_lane: directed self-checking bench for dmem_byte_lane
// (DEPTH_WORDS 256). Inputs change 1 time unit after a rising edge and
// outputs are sampled at that same point.
module tb_dmem_byte_lane;
  import dmem_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  dmem_byte_lane_if #(.ADDR_W(32)) bus ();

  dmem_byte_lane #(
    .DEPTH_WORDS (256),
    .ADDR_W      (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  // One request, accepted on the next edge; returns the response seen
  // just after that edge.
  task automatic xfer(input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd,
                      output logic v, output logic [31:0] rd,
                      output logic e);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    v  = bus.rsp_valid;
    rd = bus.rsp_rdata;
    e  = bus.rsp_error;
  endtask

  task automatic ld(input string tag, input logic [2:0] f3,
                    input logic [31:0] addr, input logic [31:0] exp_d,
                    input logic exp_e);
    logic v, e;
    logic [31:0] rd;
    xfer(1'b0, f3, addr, 32'd0, v, rd, e);
    check({tag, "/valid"}, 32'(v), 32'd1);
    check({tag, "/rdata"}, rd, exp_d);
    check({tag, "/error"}, 32'(e), 32'(exp_e));
  endtask

  task automatic st(input string tag, input logic [2:0] f3,
                    input logic [31:0] addr, input logic [31:0] wd,
                    input logic exp_e);
    logic v, e;
    logic [31:0] rd;
    xfer(1'b1, f3, addr, wd, v, rd, e);
    check({tag, "/valid"}, 32'(v), 32'd1);
    check({tag, "/rdata"}, rd, 32'd0);
    check({tag, "/error"}, 32'(e), 32'(exp_e));
  endtask

  // Counts edges while init_busy is high, bounded to 1000 cycles.
  task automatic wait_init(input string tag);
    int n;
    n = 0;
    while (bus.init_busy && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "/busy_cycles"}, 32'(n), 32'd256);
    check({tag, "/ready"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    n_checks       = 0;
    n_pass         = 0;
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;

    repeat (2) @(posedge clk);
    #1;
    check("reset/ready", 32'(bus.req_ready), 32'd0);
    check("reset/rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset/rsp_rdata", bus.rsp_rdata, 32'd0);
    check("reset/rsp_error", 32'(bus.rsp_error), 32'd0);
    check("reset/init_busy", 32'(bus.init_busy), 32'd1);

    rst = 1'b0;
    wait_init("init1");

    // Init pattern, including a positive sign-extended byte and top word.
    ld("init_lw_10", F3_W, 32'h10, 32'h13121110, 1'b0);
    ld("init_lb_10", F3_B, 32'h10, 32'h00000010, 1'b0);
    ld("init_lw_3fc", F3_W, 32'h3FC, 32'hFFFEFDFC, 1'b0);

    // Word store then sign/zero-extended sub-word loads.
    st("sw_20", F3_W, 32'h20, 32'hDEADBEEF, 1'b0);
    ld("lb_23", F3_B, 32'h23, 32'hFFFFFFDE, 1'b0);
    ld("lbu_23", F3_BU, 32'h23, 32'h000000DE, 1'b0);
    ld("lh_20", F3_H, 32'h20, 32'hFFFFBEEF, 1'b0);
    ld("lhu_22", F3_HU, 32'h22, 32'h0000DEAD, 1'b0);

    // Byte store immediately followed by a load of the same word.
    st("sb_21", F3_B, 32'h21, 32'h0000005A, 1'b0);
    ld("lw_20_after_sb", F3_W, 32'h20, 32'hDEAD5AEF, 1'b0);

    // Upper-half store into an init word.
    st("sh_26", F3_H, 32'h26, 32'h12348765, 1'b0);
    ld("lh_26", F3_H, 32'h26, 32'hFFFF8765, 1'b0);
    ld("lw_24", F3_W, 32'h24, 32'h87652524, 1'b0);

    // Errors: no write, rdata 0, error 1.
    ld("lh_21_misalign", F3_H, 32'h21, 32'h0, 1'b1);
    ld("lw_20_chk1", F3_W, 32'h20, 32'hDEAD5AEF, 1'b0);
    st("sw_22_misalign", F3_W, 32'h22, 32'h11111111, 1'b1);
    ld("lw_20_chk2", F3_W, 32'h20, 32'hDEAD5AEF, 1'b0);
    ld("ld_f3_011", 3'b011, 32'h20, 32'h0, 1'b1);
    ld("lw_20_chk3", F3_W, 32'h20, 32'hDEAD5AEF, 1'b0);
    st("st_f3_100", 3'b100, 32'h20, 32'h22222222, 1'b1);
    ld("lw_20_chk4", F3_W, 32'h20, 32'hDEAD5AEF, 1'b0);
    ld("lw_21_misalign", F3_W, 32'h21, 32'h0, 1'b1);

    // Address wrap.
    st("sw_400", F3_W, 32'h400, 32'hCAFEF00D, 1'b0);
    ld("lw_000_wrap", F3_W, 32'h000, 32'hCAFEF00D, 1'b0);

    // Response is a single-cycle pulse.
    @(posedge clk);
    #1;
    check("pulse/rsp_valid", 32'(bus.rsp_valid), 32'd0);

    // Reset right after an accepted load drops the response.
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = F3_W;
    bus.req_addr   = 32'h10;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_mid/rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_mid/rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst_mid/init_busy", 32'(bus.init_busy), 32'd1);
    check("rst_mid/ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_init("init2");

    // Init rewrote the modified words.
    ld("reinit_lw_20", F3_W, 32'h20, 32'h23222120, 1'b0);
    ld("reinit_lw_000", F3_W, 32'h000, 32'h03020100, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
